spi_top_module: RTL and testbench

- Self-contained SPI loopback block: an SPI master and an SPI slave share one clock domain and are wired together internally.
- One tx_enable pulse runs a single full-duplex 8-bit exchange (SPI mode 0, MSB first).
- Master sends MASTER_TX_DATA to the slave; slave returns SLAVE_TX_DATA to the master.
- Used as a protocol demonstrator and bring-up block; bus signals are exported for observation.

---
 rtl/spi_pkg.sv | 16 +
 rtl/spi_master.sv | 129 ++++++++++++
 rtl/spi_slave.sv | 86 ++++++++
 rtl/spi_top_module.sv | 53 +++++
 tb/tb_spi_top_module.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared constants and master FSM state type for the SPI loopback block.
package spi_pkg;

   localparam int                        SPI_DATA_WIDTH = 8;
   localparam logic [SPI_DATA_WIDTH-1:0] SPI_MASTER_TX  = 8'hB5;
   localparam logic [SPI_DATA_WIDTH-1:0] SPI_SLAVE_TX   = 8'hC8;
   localparam int                        SPI_CLK_DIV    = 4;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SETUP    = 2'd1,
      ST_TRANSFER = 2'd2,
      ST_FINISH   = 2'd3
   } spi_state_e;

endpackage

// File: rtl/spi_master.sv
// SPI mode-0 master: start strobe, sclk divider, MSB-first full-duplex shifters.
module spi_master
   import spi_pkg::*;
#(
   parameter int                    DATA_WIDTH = SPI_DATA_WIDTH,
   parameter logic [DATA_WIDTH-1:0] TX_DATA    = SPI_MASTER_TX,
   parameter int                    CLK_DIV    = SPI_CLK_DIV
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  tx_enable_i,
   input  logic                  miso_i,
   output logic                  sclk_o,
   output logic                  mosi_o,
   output logic                  cs_n_o,
   output logic [DATA_WIDTH-1:0] rx_data_o,
   output spi_state_e            state_o
);

   localparam int                DIV_W     = $clog2(CLK_DIV + 1);
   localparam int                HALF_W    = $clog2(2 * DATA_WIDTH);
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0]  DIV_FIN   = DIV_W'(CLK_DIV);
   localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * DATA_WIDTH - 1);
   localparam logic [HALF_W-1:0] RISE_LAST = HALF_W'(2 * DATA_WIDTH - 2);

   spi_state_e             state_q, state_d;
   logic [DIV_W-1:0]       div_q, div_d;
   logic [HALF_W-1:0]      half_q, half_d;
   logic                   sclk_q, sclk_d;
   logic                   cs_n_q, cs_n_d;
   logic [DATA_WIDTH-1:0]  tx_sr_q, tx_sr_d;
   logic [DATA_WIDTH-1:0]  rx_sr_q, rx_sr_d;
   logic [DATA_WIDTH-1:0]  rx_data_q, rx_data_d;
   logic [DATA_WIDTH-1:0]  rx_shift;

   // tx_enable is a plain strobe with no ready: it is accepted only on a
   // cycle where the FSM sits in IDLE and silently dropped otherwise.
   assign rx_shift = {rx_sr_q[DATA_WIDTH-2:0], miso_i};

   always_comb begin
      state_d   = state_q;
      div_d     = div_q;
      half_d    = half_q;
      sclk_d    = sclk_q;
      cs_n_d    = cs_n_q;
      tx_sr_d   = tx_sr_q;
      rx_sr_d   = rx_sr_q;
      rx_data_d = rx_data_q;
      case (state_q)
         ST_IDLE: begin
            div_d = '0;
            if (tx_enable_i) begin
               state_d = ST_SETUP;
               cs_n_d  = 1'b0;
               tx_sr_d = TX_DATA;
            end
         end
         ST_SETUP: begin
            if (div_q == DIV_LAST) begin
               div_d   = '0;
               half_d  = '0;
               state_d = ST_TRANSFER;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         ST_TRANSFER: begin
            if (div_q == DIV_LAST) begin
               div_d  = '0;
               sclk_d = ~sclk_q;
               half_d = half_q + 1'b1;
               if (!sclk_q) begin
                  rx_sr_d = rx_shift;
                  if (half_q == RISE_LAST) rx_data_d = rx_shift;
               end else if (half_q == HALF_LAST) begin
                  // Last falling edge: mosi keeps the LSB until chip select releases.
                  half_d  = '0;
                  state_d = ST_FINISH;
               end else begin
                  tx_sr_d = tx_sr_q << 1;
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         ST_FINISH: begin
            if (div_q == DIV_FIN) begin
               div_d   = '0;
               cs_n_d  = 1'b1;
               tx_sr_d = '0;
               state_d = ST_IDLE;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ST_IDLE;
         div_q     <= '0;
         half_q    <= '0;
         sclk_q    <= 1'b0;
         cs_n_q    <= 1'b1;
         tx_sr_q   <= '0;
         rx_sr_q   <= '0;
         rx_data_q <= '0;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         half_q    <= half_d;
         sclk_q    <= sclk_d;
         cs_n_q    <= cs_n_d;
         tx_sr_q   <= tx_sr_d;
         rx_sr_q   <= rx_sr_d;
         rx_data_q <= rx_data_d;
      end
   end

   assign sclk_o    = sclk_q;
   assign cs_n_o    = cs_n_q;
   assign mosi_o    = tx_sr_q[DATA_WIDTH-1];
   assign rx_data_o = rx_data_q;
   assign state_o   = state_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave in the master's clock domain; bus edges found by one-cycle delayed copies.
module spi_slave
   import spi_pkg::*;
#(
   parameter int                    DATA_WIDTH = SPI_DATA_WIDTH,
   parameter logic [DATA_WIDTH-1:0] TX_DATA    = SPI_SLAVE_TX
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  sclk_i,
   input  logic                  mosi_i,
   input  logic                  cs_n_i,
   output logic                  miso_o,
   output logic [DATA_WIDTH-1:0] rx_data_o,
   output logic                  done_o
);

   localparam int               CNT_W    = $clog2(DATA_WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

   logic                  sclk_prev_q;
   logic                  cs_prev_q;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] rx_sr_q, rx_sr_d;
   logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d;
   logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
   logic                  done_q, done_d;
   logic                  sclk_rise, sclk_fall, cs_fall, cs_rise;
   logic [DATA_WIDTH-1:0] rx_shift;

   assign sclk_rise = sclk_i & ~sclk_prev_q;
   assign sclk_fall = ~sclk_i & sclk_prev_q;
   assign cs_fall   = ~cs_n_i & cs_prev_q;
   assign cs_rise   = cs_n_i & ~cs_prev_q;
   assign rx_shift  = {rx_sr_q[DATA_WIDTH-2:0], mosi_i};

   always_comb begin
      cnt_d     = cnt_q;
      rx_sr_d   = rx_sr_q;
      tx_sr_d   = tx_sr_q;
      rx_data_d = rx_data_q;
      done_d    = done_q;
      if (cs_fall) begin
         done_d  = 1'b0;
         cnt_d   = '0;
         tx_sr_d = TX_DATA;
      end else if (cs_rise) begin
         // A short count means the transfer was cut off: leave done low.
         if (cnt_q == CNT_FULL) done_d = 1'b1;
         tx_sr_d = '0;
      end else if (!cs_n_i) begin
         if (sclk_rise) begin
            rx_sr_d = rx_shift;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) rx_data_d = rx_shift;
         end
         if (sclk_fall) tx_sr_d = tx_sr_q << 1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sclk_prev_q <= 1'b0;
         cs_prev_q   <= 1'b1;
         cnt_q       <= '0;
         rx_sr_q     <= '0;
         tx_sr_q     <= '0;
         rx_data_q   <= '0;
         done_q      <= 1'b0;
      end else begin
         sclk_prev_q <= sclk_i;
         cs_prev_q   <= cs_n_i;
         cnt_q       <= cnt_d;
         rx_sr_q     <= rx_sr_d;
         tx_sr_q     <= tx_sr_d;
         rx_data_q   <= rx_data_d;
         done_q      <= done_d;
      end
   end

   assign miso_o    = tx_sr_q[DATA_WIDTH-1];
   assign rx_data_o = rx_data_q;
   assign done_o    = done_q;

endmodule

// File: rtl/spi_top_module.sv
// SPI loopback: master and slave wired together, bus exported for observation.
module spi_top_module
   import spi_pkg::*;
#(
   parameter int                    DATA_WIDTH     = SPI_DATA_WIDTH,
   parameter logic [DATA_WIDTH-1:0] MASTER_TX_DATA = SPI_MASTER_TX,
   parameter logic [DATA_WIDTH-1:0] SLAVE_TX_DATA  = SPI_SLAVE_TX,
   parameter int                    CLK_DIV        = SPI_CLK_DIV
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  tx_enable,
   output logic [DATA_WIDTH-1:0] slave_received_data,
   output logic [DATA_WIDTH-1:0] master_received_data,
   output logic                  slave_done,
   output logic                  sclk,
   output logic                  mosi,
   output logic                  miso,
   output logic                  chip_select,
   output spi_state_e            master_state_o
);

   spi_master #(
      .DATA_WIDTH (DATA_WIDTH),
      .TX_DATA    (MASTER_TX_DATA),
      .CLK_DIV    (CLK_DIV)
   ) u_master (
      .clk_i       (clk),
      .rst_ni      (reset),
      .tx_enable_i (tx_enable),
      .miso_i      (miso),
      .sclk_o      (sclk),
      .mosi_o      (mosi),
      .cs_n_o      (chip_select),
      .rx_data_o   (master_received_data),
      .state_o     (master_state_o)
   );

   spi_slave #(
      .DATA_WIDTH (DATA_WIDTH),
      .TX_DATA    (SLAVE_TX_DATA)
   ) u_slave (
      .clk_i     (clk),
      .rst_ni    (reset),
      .sclk_i    (sclk),
      .mosi_i    (mosi),
      .cs_n_i    (chip_select),
      .miso_o    (miso),
      .rx_data_o (slave_received_data),
      .done_o    (slave_done)
   );

endmodule

// File: tb/tb_spi_top_module.sv
// Bench for spi_top_module: timeline model of one exchange, per-cycle compare, directed and random tx_enable/reset stimulus.
module tb_spi_top_module;
   import spi_pkg::*;

   localparam int            DW  = 8;
   localparam int            CD  = 4;
   localparam int            LAT = (2*DW + 2)*CD + 2;
   localparam logic [DW-1:0] MTX = 8'hB5;
   localparam logic [DW-1:0] STX = 8'hC8;

   logic          clk = 1'b0;
   logic          reset;
   logic          tx_enable;
   logic [DW-1:0] slave_received_data;
   logic [DW-1:0] master_received_data;
   logic          slave_done, sclk, mosi, miso, chip_select;
   spi_state_e    master_state;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   spi_top_module dut (
      .clk                  (clk),
      .reset                (reset),
      .tx_enable            (tx_enable),
      .slave_received_data  (slave_received_data),
      .master_received_data (master_received_data),
      .slave_done           (slave_done),
      .sclk                 (sclk),
      .mosi                 (mosi),
      .miso                 (miso),
      .chip_select          (chip_select),
      .master_state_o       (master_state)
   );

   always #5 clk = ~clk;

   // Reference: a transfer is an accept edge plus a fixed timeline measured from it.
   bit            act    = 1'b0;
   int            acc    = 0;
   bit            done_m = 1'b0;
   logic [DW-1:0] srx_m  = '0;
   logic [DW-1:0] mrx_m  = '0;

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (reset !== 1'b1) begin
         act = 1'b0; done_m = 1'b0; srx_m = '0; mrx_m = '0;
      end else begin
         if (act && cyc - acc == LAT) done_m = 1'b1;
         if ((!act || cyc - acc >= LAT) && tx_enable) begin
            acc = cyc;
            act = 1'b1;
         end
         if (act && cyc - acc == 1) done_m = 1'b0;
         if (act && cyc - acc == 2*DW*CD) mrx_m = STX;
         if (act && cyc - acc == 2*DW*CD + 1) srx_m = MTX;
      end
   end

   function automatic void expect_bus(output logic e_cs, output logic e_sclk, output logic e_mosi);
      int t, tog, falls;
      e_cs = 1'b1; e_sclk = 1'b0; e_mosi = 1'b0;
      t = cyc - acc;
      if (act && t < LAT - 1) begin
         tog = t / CD - 1;
         if (tog < 0) tog = 0;
         if (tog > 2*DW) tog = 2*DW;
         falls = tog / 2;
         if (falls > DW - 1) falls = DW - 1;
         e_cs   = 1'b0;
         e_sclk = tog[0];
         e_mosi = MTX[DW-1-falls];
      end
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Scoreboard: per-cycle compare plus bit capture at every sclk rise.
   logic prev_sclk = 1'b0;
   logic prev_cs   = 1'b1;
   logic prev_done = 1'b0;
   logic mq[$];
   logic sq[$];
   int   xfers      = 0;
   int   done_rises = 0;

   always @(negedge clk) begin
      logic          e_cs, e_sclk, e_mosi;
      logic [DW-1:0] mb, sb;
      if (reset !== 1'b1) begin
         check("rst_cs", chip_select, 1);
         check("rst_sclk", sclk, 0);
         check("rst_mosi", mosi, 0);
         check("rst_miso", miso, 0);
         check("rst_done", slave_done, 0);
         check("rst_srx", slave_received_data, 0);
         check("rst_mrx", master_received_data, 0);
         mq.delete(); sq.delete();
         prev_sclk = 1'b0; prev_cs = 1'b1; prev_done = 1'b0;
      end else begin
         expect_bus(e_cs, e_sclk, e_mosi);
         check("cs", chip_select, e_cs);
         check("sclk", sclk, e_sclk);
         check("mosi", mosi, e_mosi);
         check("done", slave_done, done_m);
         check("srx", slave_received_data, srx_m);
         check("mrx", master_received_data, mrx_m);
         if (!chip_select && sclk && !prev_sclk) begin
            mq.push_back(mosi);
            sq.push_back(miso);
         end
         if (slave_done && !prev_done) done_rises++;
         if (chip_select && !prev_cs) begin
            check("rise_count", mq.size(), DW);
            if (mq.size() == DW) begin
               mb = '0; sb = '0;
               for (int i = 0; i < DW; i++) begin
                  mb = {mb[DW-2:0], mq[i]};
                  sb = {sb[DW-2:0], sq[i]};
               end
               check("mosi_bits", mb, 8'b10110101);
               check("miso_bits", sb, 8'b11001000);
            end
            mq.delete(); sq.delete();
            xfers++;
         end
         prev_sclk = sclk; prev_cs = chip_select; prev_done = slave_done;
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic pulse_tx(input int len);
      tx_enable = 1'b1;
      step(len);
      tx_enable = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int i = 0;
      while (act && (cyc - acc) < LAT + 1 && i < budget) begin
         step(1);
         i++;
      end
      check("idle_timeout", (i < budget), 1);
   endtask

   initial begin
      int t0, x0, d0, i;
      reset = 1'b0; tx_enable = 1'b0;
      #50;
      @(negedge clk); #1;
      reset = 1'b1;
      step(1);
      check("init_state", master_state, ST_IDLE);
      check("init_cs", chip_select, 1);
      check("init_sclk", sclk, 0);
      check("init_done", slave_done, 0);
      check("init_srx", slave_received_data, 0);
      check("init_mrx", master_received_data, 0);

      // Single exchange and its latency.
      t0 = cyc;
      pulse_tx(1);
      i = 0;
      while (chip_select && i < 20) begin step(1); i++; end
      while (!chip_select && i < 200) begin step(1); i++; end
      check("latency", cyc - t0, 74);
      step(3);
      check("one_srx", slave_received_data, 181);
      check("one_mrx", master_received_data, 200);
      check("one_done", slave_done, 1);

      // Retrigger attempts while busy must be ignored.
      x0 = xfers;
      pulse_tx(1);
      for (int k = 0; k < 12; k++) begin
         step($urandom_range(1, 4));
         pulse_tx(1);
      end
      wait_idle(200);
      step(2);
      check("retrig_xfers", xfers - x0, 1);
      check("retrig_done", slave_done, 1);

      // Reset right after the 4th sclk rise.
      pulse_tx(1);
      i = 0;
      while (mq.size() < 4 && i < 100) begin step(1); i++; end
      check("wait_rise4", mq.size(), 4);
      reset = 1'b0;
      #1;
      check("abort_cs", chip_select, 1);
      check("abort_sclk", sclk, 0);
      check("abort_done", slave_done, 0);
      check("abort_srx", slave_received_data, 0);
      check("abort_mrx", master_received_data, 0);
      step(3);
      reset = 1'b1;
      step(2);
      pulse_tx(1);
      wait_idle(200);
      step(2);
      check("post_abort_srx", slave_received_data, 181);
      check("post_abort_mrx", master_received_data, 200);
      check("post_abort_done", slave_done, 1);

      // Back-to-back: tx_enable held through the first exchange.
      d0 = done_rises; x0 = xfers;
      pulse_tx(LAT + 3);
      wait_idle(300);
      step(2);
      check("b2b_xfers", xfers - x0, 2);
      check("b2b_done_rises", done_rises - d0, 2);
      check("b2b_srx", slave_received_data, 181);
      check("b2b_mrx", master_received_data, 200);

      // Random strobes, hold lengths and occasional resets.
      for (int r = 0; r < 25; r++) begin
         step($urandom_range(0, 8));
         pulse_tx($urandom_range(1, 90));
         if ($urandom_range(0, 5) == 0) begin
            step($urandom_range(0, 60));
            reset = 1'b0;
            step($urandom_range(1, 3));
            reset = 1'b1;
         end
         wait_idle(300);
      end
      step(4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
